// File: rtl/cmd_timing_checker.sv
// Purpose: per-bank DDR timing tracker. It answers the earliest legal slot in the
//          current 4-slot window and records issued commands.
// Latency: the query (valid/offset) is combinational from registered state.
//          An issue updates the counters at the next clock edge. viol is
//          registered and pulses in the cycle after an illegal issue.
// Backpressure: none. The block only answers queries and records issues.
// Ports: clk/rst_n; cmd/bank is the query and also names the issued command;
//        valid/offset is the answer; issue/issued_offset reports placement;
//        viol/viol_bank reports illegal issues.

`ifndef BANK_SZ
`define BANK_SZ 3
`endif
`ifndef DEC_DDR_CMD_SZ
`define DEC_DDR_CMD_SZ 3
`endif
`ifndef DDR_NOP
`define DDR_NOP   3'd0
`define DDR_ACT   3'd1
`define DDR_PRE   3'd2
`define DDR_READ  3'd3
`define DDR_WRITE 3'd4
`endif

module cmd_timing_checker #(
    parameter int BANKS = 2**`BANK_SZ,
    parameter int CNT_W = 6,
    parameter int T_RCD = 6,
    parameter int T_RP  = 6,
    parameter int T_RAS = 15,
    parameter int T_RC  = 21,
    parameter int T_RRD = 4,
    parameter int T_RTP = 4,
    parameter int T_WTP = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [`DEC_DDR_CMD_SZ-1:0] cmd,
    input  logic [`BANK_SZ-1:0]        bank,
    output logic                       valid,
    output logic [1:0]                 offset,
    input  logic                       issue,
    input  logic [1:0]                 issued_offset,
    output logic                       viol,
    output logic [`BANK_SZ-1:0]        viol_bank
);

    localparam logic [CNT_W-1:0] SLOTS   = CNT_W'(4);
    localparam logic [CNT_W:0]   SLOTS_W = (CNT_W+1)'(4);
    localparam logic [CNT_W:0]   CMAX    = {1'b0, {CNT_W{1'b1}}};
    localparam logic [CNT_W:0]   T_RCD_W = (CNT_W+1)'(T_RCD);
    localparam logic [CNT_W:0]   T_RP_W  = (CNT_W+1)'(T_RP);
    localparam logic [CNT_W:0]   T_RAS_W = (CNT_W+1)'(T_RAS);
    localparam logic [CNT_W:0]   T_RC_W  = (CNT_W+1)'(T_RC);
    localparam logic [CNT_W:0]   T_RRD_W = (CNT_W+1)'(T_RRD);
    localparam logic [CNT_W:0]   T_RTP_W = (CNT_W+1)'(T_RTP);
    localparam logic [CNT_W:0]   T_WTP_W = (CNT_W+1)'(T_WTP);

    // Each counter holds the number of slots, counted from slot 0 of this cycle,
    // before the constrained command becomes legal.
    logic [CNT_W-1:0] act2rw  [BANKS];
    logic [CNT_W-1:0] act2pre [BANKS];
    logic [CNT_W-1:0] act2act [BANKS];
    logic [CNT_W-1:0] pre2act [BANKS];
    logic [CNT_W-1:0] rrd;

    logic [CNT_W-1:0] n_act2rw  [BANKS];
    logic [CNT_W-1:0] n_act2pre [BANKS];
    logic [CNT_W-1:0] n_act2act [BANKS];
    logic [CNT_W-1:0] n_pre2act [BANKS];
    logic [CNT_W-1:0] n_rrd;

    logic [CNT_W-1:0] w;
    logic             tracked;
    logic             bad;

    // One fabric cycle advances time by 4 slots.
    function automatic logic [CNT_W-1:0] decay(input logic [CNT_W-1:0] c);
        return (c > SLOTS) ? c - SLOTS : '0;
    endfunction

    // Merge a new constraint (o + t - 4, floored at 0 and clamped) with the
    // already decayed count. The stricter of the two wins.
    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] base,
                                              input logic [1:0]       o,
                                              input logic [CNT_W:0]   t);
        logic [CNT_W:0] sum;
        logic [CNT_W:0] cand;
        sum  = (CNT_W+1)'(o) + t;
        cand = (sum > SLOTS_W) ? sum - SLOTS_W : '0;
        if (cand > CMAX) cand = CMAX;
        return ({1'b0, base} > cand) ? base : cand[CNT_W-1:0];
    endfunction

    always_comb begin
        w = '0;
        case (cmd)
            `DDR_ACT: begin
                w = act2act[bank];
                if (pre2act[bank] > w) w = pre2act[bank];
                if (rrd > w)           w = rrd;
            end
            `DDR_PRE:              w = act2pre[bank];
            `DDR_READ, `DDR_WRITE: w = act2rw[bank];
            default:               w = '0;
        endcase
    end

    assign valid   = (w < SLOTS);
    assign offset  = valid ? w[1:0] : 2'b00;
    assign tracked = (cmd == `DDR_ACT) || (cmd == `DDR_PRE) ||
                     (cmd == `DDR_READ) || (cmd == `DDR_WRITE);
    // When the command is not legal in this window, any slot is a violation.
    // When it is legal, a slot earlier than offset is a violation.
    assign bad     = issue && tracked && (!valid || (issued_offset < offset));

    always_comb begin
        for (int i = 0; i < BANKS; i++) begin
            n_act2rw[i]  = decay(act2rw[i]);
            n_act2pre[i] = decay(act2pre[i]);
            n_act2act[i] = decay(act2act[i]);
            n_pre2act[i] = decay(pre2act[i]);
        end
        n_rrd = decay(rrd);
        // Illegal issues are still recorded, because the command really went out.
        if (issue) begin
            case (cmd)
                `DDR_ACT: begin
                    n_act2rw[bank]  = bump(n_act2rw[bank],  issued_offset, T_RCD_W);
                    n_act2pre[bank] = bump(n_act2pre[bank], issued_offset, T_RAS_W);
                    n_act2act[bank] = bump(n_act2act[bank], issued_offset, T_RC_W);
                    n_rrd           = bump(n_rrd,           issued_offset, T_RRD_W);
                end
                `DDR_PRE:   n_pre2act[bank] = bump(n_pre2act[bank], issued_offset, T_RP_W);
                `DDR_READ:  n_act2pre[bank] = bump(n_act2pre[bank], issued_offset, T_RTP_W);
                `DDR_WRITE: n_act2pre[bank] = bump(n_act2pre[bank], issued_offset, T_WTP_W);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BANKS; i++) begin
                act2rw[i]  <= '0;
                act2pre[i] <= '0;
                act2act[i] <= '0;
                pre2act[i] <= '0;
            end
            rrd       <= '0;
            viol      <= 1'b0;
            viol_bank <= '0;
        end else begin
            act2rw  <= n_act2rw;
            act2pre <= n_act2pre;
            act2act <= n_act2act;
            pre2act <= n_pre2act;
            rrd     <= n_rrd;
            viol    <= bad;
            if (bad) viol_bank <= bank;
        end
    end

endmodule

// File: tb/tb_cmd_timing_checker.sv
`ifndef BANK_SZ
`define BANK_SZ 3
`endif
`ifndef DEC_DDR_CMD_SZ
`define DEC_DDR_CMD_SZ 3
`endif
`ifndef DDR_NOP
`define DDR_NOP   3'd0
`define DDR_ACT   3'd1
`define DDR_PRE   3'd2
`define DDR_READ  3'd3
`define DDR_WRITE 3'd4
`endif

module tb_cmd_timing_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] cmd = 3'd0;
    logic [2:0] bank = 3'd0;
    logic       valid;
    logic [1:0] offset;
    logic       issue = 1'b0;
    logic [1:0] issued_offset = 2'd0;
    logic       viol;
    logic [2:0] viol_bank;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic       vld;
        logic [1:0] off;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    always #5 clk = ~clk;

    cmd_timing_checker dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .bank(bank),
        .valid(valid), .offset(offset), .issue(issue),
        .issued_offset(issued_offset), .viol(viol), .viol_bank(viol_bank)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (required: finish earlier)");
        $fatal(1);
    end

    // Drive one cycle's inputs just after the active edge.
    task automatic drive(input logic [2:0] c, input logic [2:0] b,
                         input logic iss, input logic [1:0] o);
        @(posedge clk);
        #1;
        cmd = c; bank = b; issue = iss; issued_offset = o;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        cmd = `DDR_NOP; bank = 3'd0; issue = 1'b0; issued_offset = 2'd0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        drive(`DDR_ACT, 3'd3, 1'b0, 2'd0);
        exp_q.push_back('{"reset_act_b3", 1'b1, 2'd0});
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (valid !== e.vld || offset !== e.off) begin
            errors++;
            $display("FAIL %s: got valid=%b offset=%0d, want valid=%b offset=%0d", e.name, valid, offset, e.vld, e.off);
        end
        checks++;
        if (viol !== 1'b0 || viol_bank !== 3'd0) begin
            errors++;
            $display("FAIL reset_viol: got viol=%b bank=%0d, want 0/0", viol, viol_bank);
        end
    endtask

    task automatic test_act_to_pre();
        do_reset();
        drive(`DDR_ACT, 3'd2, 1'b1, 2'd0);
        exp_q.push_back('{"tras_n1", 1'b0, 2'd0});
        exp_q.push_back('{"tras_n2", 1'b0, 2'd0});
        exp_q.push_back('{"tras_n3", 1'b1, 2'd3});
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            drive(`DDR_PRE, 3'd2, 1'b0, 2'd0);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (valid !== e.vld || offset !== e.off) begin
                errors++;
                $display("FAIL %s: got valid=%b offset=%0d, want valid=%b offset=%0d", e.name, valid, offset, e.vld, e.off);
            end
        end
    endtask

    task automatic test_pre_to_act();
        do_reset();
        drive(`DDR_PRE, 3'd1, 1'b1, 2'd2);
        exp_q.push_back('{"trp_n1", 1'b0, 2'd0});
        exp_q.push_back('{"trp_n2", 1'b1, 2'd0});
        for (int k = 0; k < 2; k++) begin
            drive(`DDR_ACT, 3'd1, 1'b0, 2'd0);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (valid !== e.vld || offset !== e.off) begin
                errors++;
                $display("FAIL %s: got valid=%b offset=%0d, want valid=%b offset=%0d", e.name, valid, offset, e.vld, e.off);
            end
        end
    endtask

    task automatic test_rrd_viol();
        do_reset();
        drive(`DDR_ACT, 3'd2, 1'b1, 2'd3);
        // In N+1, query ACT bank 5 and issue it too early, at slot 1.
        drive(`DDR_ACT, 3'd5, 1'b1, 2'd1);
        exp_q.push_back('{"trrd_b5", 1'b1, 2'd3});
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (valid !== e.vld || offset !== e.off) begin
            errors++;
            $display("FAIL %s: got valid=%b offset=%0d, want valid=%b offset=%0d", e.name, valid, offset, e.vld, e.off);
        end
        drive(`DDR_NOP, 3'd0, 1'b0, 2'd0);
        @(negedge clk);
        checks++;
        if (viol !== 1'b1 || viol_bank !== 3'd5) begin
            errors++;
            $display("FAIL rrd_viol_pulse: got viol=%b bank=%0d, want 1/5", viol, viol_bank);
        end
        drive(`DDR_NOP, 3'd0, 1'b0, 2'd0);
        @(negedge clk);
        checks++;
        if (viol !== 1'b0 || viol_bank !== 3'd5) begin
            errors++;
            $display("FAIL rrd_viol_hold: got viol=%b bank=%0d, want 0/5", viol, viol_bank);
        end
    endtask

    task automatic test_rc_pre_combo();
        do_reset();
        drive(`DDR_ACT, 3'd4, 1'b1, 2'd0);
        drive(`DDR_NOP, 3'd4, 1'b0, 2'd0);
        drive(`DDR_NOP, 3'd4, 1'b0, 2'd0);
        // N+3: the earliest legal PRE is at slot 15, which is offset 3.
        drive(`DDR_PRE, 3'd4, 1'b1, 2'd3);
        exp_q.push_back('{"rc_pre_legal", 1'b1, 2'd3});
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (valid !== e.vld || offset !== e.off) begin
            errors++;
            $display("FAIL %s: got valid=%b offset=%0d, want valid=%b offset=%0d", e.name, valid, offset, e.vld, e.off);
        end
        exp_q.push_back('{"rc_act_n4", 1'b0, 2'd0});
        exp_q.push_back('{"rc_act_n5", 1'b1, 2'd1});
        for (int k = 0; k < 2; k++) begin
            drive(`DDR_ACT, 3'd4, 1'b0, 2'd0);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (valid !== e.vld || offset !== e.off) begin
                errors++;
                $display("FAIL %s: got valid=%b offset=%0d, want valid=%b offset=%0d", e.name, valid, offset, e.vld, e.off);
            end
        end
        checks++;
        if (viol !== 1'b0) begin
            errors++;
            $display("FAIL rc_no_viol: got viol=%b, want 0", viol);
        end
    endtask

    task automatic test_rw();
        do_reset();
        drive(`DDR_ACT, 3'd6, 1'b1, 2'd1);
        // N+1: tRCD is met at slot 7, which is offset 3. Issue READ there.
        // A NOP query during the same wait must always be legal.
        drive(`DDR_READ, 3'd6, 1'b1, 2'd3);
        exp_q.push_back('{"trcd_rd", 1'b1, 2'd3});
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (valid !== e.vld || offset !== e.off) begin
            errors++;
            $display("FAIL %s: got valid=%b offset=%0d, want valid=%b offset=%0d", e.name, valid, offset, e.vld, e.off);
        end
        drive(`DDR_WRITE, 3'd6, 1'b1, 2'd0);
        exp_q.push_back('{"wr_after_rd", 1'b1, 2'd0});
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (valid !== e.vld || offset !== e.off) begin
            errors++;
            $display("FAIL %s: got valid=%b offset=%0d, want valid=%b offset=%0d", e.name, valid, offset, e.vld, e.off);
        end
        checks++;
        if (viol !== 1'b0) begin
            errors++;
            $display("FAIL rd_legal_no_viol: got viol=%b, want 0", viol);
        end
        // WR at N+2 slot 0 pushes PRE to 12 slots out: 12, 8, 4 (W=4 not legal), then 0.
        exp_q.push_back('{"twtp_n3", 1'b0, 2'd0});
        exp_q.push_back('{"twtp_n4", 1'b0, 2'd0});
        exp_q.push_back('{"twtp_n5_w4", 1'b0, 2'd0});
        exp_q.push_back('{"twtp_n6", 1'b1, 2'd0});
        for (int k = 0; k < 4; k++) begin
            drive(`DDR_PRE, 3'd6, 1'b0, 2'd0);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (valid !== e.vld || offset !== e.off) begin
                errors++;
                $display("FAIL %s: got valid=%b offset=%0d, want valid=%b offset=%0d", e.name, valid, offset, e.vld, e.off);
            end
        end
        do_reset();
        drive(`DDR_ACT, 3'd6, 1'b1, 2'd0);
        drive(`DDR_NOP, 3'd6, 1'b0, 2'd0);
        exp_q.push_back('{"nop_always_ok", 1'b1, 2'd0});
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (valid !== e.vld || offset !== e.off) begin
            errors++;
            $display("FAIL %s: got valid=%b offset=%0d, want valid=%b offset=%0d", e.name, valid, offset, e.vld, e.off);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive(`DDR_ACT, 3'd0, 1'b1, 2'd0);
        // Issue a too-early PRE so that a viol is pending when reset hits.
        drive(`DDR_PRE, 3'd0, 1'b1, 2'd0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        issue = 1'b0;
        @(negedge clk);
        checks++;
        if (viol !== 1'b0 || viol_bank !== 3'd0) begin
            errors++;
            $display("FAIL midreset_viol: got viol=%b bank=%0d, want 0/0", viol, viol_bank);
        end
        drive(`DDR_PRE, 3'd0, 1'b0, 2'd0);
        exp_q.push_back('{"midreset_pre_b0", 1'b1, 2'd0});
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (valid !== e.vld || offset !== e.off) begin
            errors++;
            $display("FAIL %s: got valid=%b offset=%0d, want valid=%b offset=%0d", e.name, valid, offset, e.vld, e.off);
        end
    endtask

    initial begin
        test_reset();
        test_act_to_pre();
        test_pre_to_act();
        test_rrd_viol();
        test_rc_pre_combo();
        test_rw();
        test_mid_reset();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
